// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch queue: default sizes, FSM state type and queue entry layout.
// The optional same-cycle response bypass is enabled with the FETCH_BYPASS_EN macro.
package fetch_pkg;

  localparam int FQ_WIDTH = 32;
  localparam int FQ_DEPTH = 4;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fq_state_e;

  // The top packs queue entries in this same {instr, pc} order at its own WIDTH.
  typedef struct packed {
    logic [FQ_WIDTH-1:0] instr;
    logic [FQ_WIDTH-1:0] pc;
  } fq_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear; used for the instruction queue and the pending-PC FIFO.
// A pop is allowed in the same cycle as a push when the FIFO is full.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Qualify requests against the current fill level.
  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && ((count != FULL_CNT) || do_pop);
  end

  // Storage array; contents past the read pointer are never observed.
  always_ff @(posedge clk) begin
    if (do_push && !clr) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and fill count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      else         wr_ptr <= wr_ptr;
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      else         rd_ptr <= rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue with credit-gated memory requests and flush draining.
// Define FETCH_BYPASS_EN to present a response in its arrival cycle when the queue is empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int WIDTH = FQ_WIDTH,
  parameter int DEPTH = FQ_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_i,
  input  logic             pc_valid_i,
  output logic             pc_ready_o,
  output logic             imem_req_o,
  output logic [WIDTH-1:0] imem_addr_o,
  input  logic             imem_gnt_i,
  input  logic             imem_rvalid_i,
  input  logic [WIDTH-1:0] imem_rdata_i,
  input  logic             flush_i,
  output logic             instr_valid_o,
  output logic [WIDTH-1:0] instr_o,
  output logic [WIDTH-1:0] instr_pc_o,
  input  logic             instr_ready_i
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  fq_state_e          state;
  logic [CW-1:0]      q_count;
  logic [CW-1:0]      p_count;
  logic [CW-1:0]      drop_cnt;
  logic [CW-1:0]      drop_next;
  logic [2*WIDTH-1:0] q_head;
  logic [2*WIDTH-1:0] q_in;
  logic [WIDTH-1:0]   p_head;
  logic [CW:0]        credit;
  logic               run_rsp;
  logic               bypass;
  logic               q_push;
  logic               q_pop;

  // The pending-PC FIFO depth is the outstanding-request count while in RUN.
  always_comb begin
    credit     = {1'b0, q_count} + {1'b0, p_count};
    imem_req_o = pc_valid_i && !flush_i && (state == RUN) && (credit < DEPTH_C);
    pc_ready_o = imem_req_o && imem_gnt_i;
    run_rsp    = (state == RUN) && !flush_i && imem_rvalid_i && (p_count != '0);
`ifdef FETCH_BYPASS_EN
    bypass     = run_rsp && (q_count == '0) && instr_ready_i;
`else
    bypass     = 1'b0;
`endif
    q_push     = run_rsp && !bypass;
    q_pop      = (q_count != '0) && instr_ready_i;
    q_in       = {imem_rdata_i, p_head};
  end

  assign imem_addr_o = pc_i;

  // Decode-side outputs are zero whenever nothing is presented.
  always_comb begin
    if (bypass) begin
      instr_valid_o = 1'b1;
      instr_o       = imem_rdata_i;
      instr_pc_o    = p_head;
    end else if (q_count != '0) begin
      instr_valid_o = 1'b1;
      {instr_o, instr_pc_o} = q_head;
    end else begin
      instr_valid_o = 1'b0;
      instr_o       = '0;
      instr_pc_o    = '0;
    end
  end

  // Responses still owed after a flush; one arriving in the flush cycle itself is not owed.
  always_comb begin
    if (state == DRAIN) begin
      drop_next = drop_cnt - CW'(imem_rvalid_i);
    end else begin
      drop_next = p_count - CW'(imem_rvalid_i && (p_count != '0));
    end
  end

  // RUN/DRAIN control and drop counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      drop_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (flush_i) begin
            drop_cnt <= drop_next;
            state    <= (drop_next != '0) ? DRAIN : RUN;
          end else begin
            drop_cnt <= '0;
            state    <= RUN;
          end
        end
        DRAIN: begin
          drop_cnt <= drop_next;
          state    <= (drop_next == '0) ? RUN : DRAIN;
        end
        default: begin
          drop_cnt <= '0;
          state    <= RUN;
        end
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (2*WIDTH),
    .DEPTH (DEPTH)
  ) u_instr_q (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush_i),
    .push      (q_push),
    .push_data (q_in),
    .pop       (q_pop),
    .pop_data  (q_head),
    .count     (q_count)
  );

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_pend_q (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush_i),
    .push      (pc_ready_o),
    .push_data (pc_i),
    .pop       (run_rsp),
    .pop_data  (p_head),
    .count     (p_count)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (default DEPTH 4, WIDTH 32).
// Also covers the FETCH_BYPASS_EN build when that macro is defined.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        pc_valid_i;
  logic        pc_ready_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        flush_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;

  int tests = 0;
  int failed = 0;

  fetch_queue dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc_i),
    .pc_valid_i    (pc_valid_i),
    .pc_ready_o    (pc_ready_o),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .flush_i       (flush_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc_i = 32'h0; pc_valid_i = 1'b0; imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0; flush_i = 1'b0; instr_ready_i = 1'b0;
    #1 rst = 1'b0;
    #2;
    tests++; if (instr_valid_o !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b expected 0", instr_valid_o); end
    tests++; if (instr_o !== 32'h0) begin failed++; $display("FAIL reset_instr: got %h expected 0", instr_o); end
    tests++; if (instr_pc_o !== 32'h0) begin failed++; $display("FAIL reset_pc: got %h expected 0", instr_pc_o); end
    tests++; if (imem_req_o !== 1'b0) begin failed++; $display("FAIL reset_req: got %b expected 0", imem_req_o); end
    #19 rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    pc_i = 32'h0; pc_valid_i = 1'b1; imem_gnt_i = 1'b1;
    #1;
    tests++; if (imem_req_o !== 1'b1) begin failed++; $display("FAIL basic_req: got %b expected 1", imem_req_o); end
    tests++; if (pc_ready_o !== 1'b1) begin failed++; $display("FAIL basic_pc_ready: got %b expected 1", pc_ready_o); end
    tests++; if (imem_addr_o !== 32'h0) begin failed++; $display("FAIL basic_addr: got %h expected 0", imem_addr_o); end
    tick();
    pc_valid_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h00500093;
    #1;
    tests++; if (instr_valid_o !== 1'b0) begin failed++; $display("FAIL basic_not_same_cycle: got %b expected 0", instr_valid_o); end
    tick();
    imem_rvalid_i = 1'b0;
    #1;
    tests++; if (instr_valid_o !== 1'b1) begin failed++; $display("FAIL basic_valid: got %b expected 1", instr_valid_o); end
    tests++; if (instr_o !== 32'h00500093) begin failed++; $display("FAIL basic_instr: got %h expected 00500093", instr_o); end
    tests++; if (instr_pc_o !== 32'h0) begin failed++; $display("FAIL basic_instr_pc: got %h expected 0", instr_pc_o); end
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    #1;
    tests++; if (instr_valid_o !== 1'b0) begin failed++; $display("FAIL basic_popped: got %b expected 0", instr_valid_o); end
    // A response with nothing outstanding must not create an entry.
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEADBEEF;
    tick();
    imem_rvalid_i = 1'b0;
    #1;
    tests++; if (instr_valid_o !== 1'b0) begin failed++; $display("FAIL stray_rvalid: got %b expected 0", instr_valid_o); end
  endtask

  task automatic test_credit();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC; exp_pc[3] = 32'h10;
    imem_gnt_i = 1'b1; pc_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc_i = 32'(i * 4);
      #1;
      tests++; if (pc_ready_o !== 1'b1) begin failed++; $display("FAIL credit_grant%0d: got %b expected 1", i, pc_ready_o); end
      tick();
    end
    pc_i = 32'h10;
    #1;
    tests++; if (imem_req_o !== 1'b0) begin failed++; $display("FAIL credit_hold_outstanding: got %b expected 0", imem_req_o); end
    imem_rvalid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      imem_rdata_i = 32'h10000000 | 32'(i * 4);
      #1;
      tests++; if (imem_req_o !== 1'b0) begin failed++; $display("FAIL credit_hold_rsp%0d: got %b expected 0", i, imem_req_o); end
      tick();
    end
    imem_rvalid_i = 1'b0; instr_ready_i = 1'b1;
    #1;
    tests++; if (instr_pc_o !== 32'h0) begin failed++; $display("FAIL credit_head: got %h expected 0", instr_pc_o); end
    tests++; if (imem_req_o !== 1'b0) begin failed++; $display("FAIL credit_hold_full: got %b expected 0", imem_req_o); end
    tick();
    instr_ready_i = 1'b0;
    #1;
    tests++; if (pc_ready_o !== 1'b1) begin failed++; $display("FAIL credit_release: got %b expected 1", pc_ready_o); end
    tests++; if (imem_addr_o !== 32'h10) begin failed++; $display("FAIL credit_addr: got %h expected 10", imem_addr_o); end
    tick();
    pc_valid_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h10000010;
    tick();
    imem_rvalid_i = 1'b0; instr_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (instr_pc_o !== exp_pc[i]) begin failed++; $display("FAIL drain_pc%0d: got %h expected %h", i, instr_pc_o, exp_pc[i]); end
      tests++; if (instr_o !== (32'h10000000 | exp_pc[i])) begin failed++; $display("FAIL drain_instr%0d: got %h expected %h", i, instr_o, 32'h10000000 | exp_pc[i]); end
      tick();
    end
    instr_ready_i = 1'b0;
    #1;
    tests++; if (instr_valid_o !== 1'b0) begin failed++; $display("FAIL drain_empty: got %b expected 0", instr_valid_o); end
  endtask

  task automatic test_flush();
    pc_valid_i = 1'b1; imem_gnt_i = 1'b1; pc_i = 32'h8;
    tick();
    pc_i = 32'hC;
    tick();
    pc_valid_i = 1'b0; imem_gnt_i = 1'b0; flush_i = 1'b1;
    tick();
    flush_i = 1'b0; pc_valid_i = 1'b1; pc_i = 32'h40; imem_gnt_i = 1'b1;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD00008;
    #1;
    tests++; if (imem_req_o !== 1'b0) begin failed++; $display("FAIL drain_req0: got %b expected 0", imem_req_o); end
    tick();
    imem_rdata_i = 32'hBAD0000C;
    #1;
    tests++; if (imem_req_o !== 1'b0) begin failed++; $display("FAIL drain_req1: got %b expected 0", imem_req_o); end
    tests++; if (instr_valid_o !== 1'b0) begin failed++; $display("FAIL drain_dropped: got %b expected 0", instr_valid_o); end
    tick();
    imem_rvalid_i = 1'b0;
    #1;
    tests++; if (pc_ready_o !== 1'b1) begin failed++; $display("FAIL flush_back_to_run: got %b expected 1", pc_ready_o); end
    tests++; if (instr_valid_o !== 1'b0) begin failed++; $display("FAIL flush_queue_empty: got %b expected 0", instr_valid_o); end
    tick();
    pc_valid_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h00000040;
    tick();
    imem_rvalid_i = 1'b0;
    #1;
    tests++; if (instr_pc_o !== 32'h40) begin failed++; $display("FAIL target_pc: got %h expected 40", instr_pc_o); end
    tests++; if (instr_o !== 32'h00000040) begin failed++; $display("FAIL target_instr: got %h expected 00000040", instr_o); end
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    #1;
    tests++; if (instr_valid_o !== 1'b0) begin failed++; $display("FAIL target_alone: got %b expected 0", instr_valid_o); end
  endtask

  task automatic test_flush_with_rsp();
    pc_valid_i = 1'b1; imem_gnt_i = 1'b1; pc_i = 32'h50;
    tick();
    pc_valid_i = 1'b0; imem_gnt_i = 1'b0; flush_i = 1'b1; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h00000050;
    tick();
    flush_i = 1'b0; imem_rvalid_i = 1'b0; pc_valid_i = 1'b1; pc_i = 32'h60;
    #1;
    tests++; if (instr_valid_o !== 1'b0) begin failed++; $display("FAIL flush_rsp_nothing_queued: got %b expected 0", instr_valid_o); end
    tests++; if (imem_req_o !== 1'b1) begin failed++; $display("FAIL flush_rsp_stays_run: got %b expected 1", imem_req_o); end
    pc_valid_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    pc_valid_i = 1'b1; imem_gnt_i = 1'b1; pc_i = 32'h0;
    tick();
    pc_i = 32'h4;
    tick();
    pc_valid_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hA0000000;
    tick();
    imem_rdata_i = 32'hA0000004;
    tick();
    imem_rvalid_i = 1'b0; pc_valid_i = 1'b1; imem_gnt_i = 1'b1; pc_i = 32'h8;
    tick();
    pc_valid_i = 1'b0; imem_gnt_i = 1'b0; pc_i = 32'h0;
    #1;
    tests++; if (instr_valid_o !== 1'b1) begin failed++; $display("FAIL rstmid_pre_valid: got %b expected 1", instr_valid_o); end
    #2 rst = 1'b0;
    #1;
    tests++; if (instr_valid_o !== 1'b0) begin failed++; $display("FAIL rstmid_valid: got %b expected 0", instr_valid_o); end
    tests++; if (instr_o !== 32'h0) begin failed++; $display("FAIL rstmid_instr: got %h expected 0", instr_o); end
    tests++; if (instr_pc_o !== 32'h0) begin failed++; $display("FAIL rstmid_pc: got %h expected 0", instr_pc_o); end
    tests++; if (imem_req_o !== 1'b0) begin failed++; $display("FAIL rstmid_req: got %b expected 0", imem_req_o); end
    #2 rst = 1'b1;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hA0000008;
    tick();
    imem_rvalid_i = 1'b0;
    #1;
    tests++; if (instr_valid_o !== 1'b0) begin failed++; $display("FAIL rstmid_stale_ignored: got %b expected 0", instr_valid_o); end
  endtask

`ifdef FETCH_BYPASS_EN
  task automatic test_bypass();
    pc_valid_i = 1'b1; imem_gnt_i = 1'b1; pc_i = 32'h20;
    tick();
    pc_valid_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h00000013; instr_ready_i = 1'b1;
    #1;
    tests++; if (instr_valid_o !== 1'b1) begin failed++; $display("FAIL bypass_valid: got %b expected 1", instr_valid_o); end
    tests++; if (instr_o !== 32'h00000013) begin failed++; $display("FAIL bypass_instr: got %h expected 00000013", instr_o); end
    tests++; if (instr_pc_o !== 32'h20) begin failed++; $display("FAIL bypass_pc: got %h expected 20", instr_pc_o); end
    tick();
    imem_rvalid_i = 1'b0;
    #1;
    tests++; if (instr_valid_o !== 1'b0) begin failed++; $display("FAIL bypass_not_stored: got %b expected 0", instr_valid_o); end
    instr_ready_i = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_credit();
    test_flush();
    test_flush_with_rsp();
    test_reset_mid();
`ifdef FETCH_BYPASS_EN
    test_bypass();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the address and instruction width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the queue entries and maximum outstanding requests (power of two, at least 2).
REQ-003 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port pc_i, input, WIDTH bits: fetch address from the PC register.
REQ-006 Port pc_valid_i, input, 1 bit: pc_i is valid.
REQ-007 Port pc_ready_o, output, 1 bit: pc_i accepted this cycle; the PC register advances only when this is high.
REQ-008 Port imem_req_o, output, 1 bit: instruction memory request.
REQ-009 Port imem_addr_o, output, WIDTH bits: request address, equal to pc_i.
REQ-010 Port imem_gnt_i, input, 1 bit: memory accepts the request.
REQ-011 Port imem_rvalid_i, input, 1 bit: read data valid; responses return in request order.
REQ-012 Port imem_rdata_i, input, WIDTH bits: instruction word.
REQ-013 Port flush_i, input, 1 bit: taken-branch redirect (PCsrc).
REQ-014 Port instr_valid_o, output, 1 bit: instr_o/instr_pc_o valid.
REQ-015 Port instr_o, output, WIDTH bits: fetched instruction.
REQ-016 Port instr_pc_o, output, WIDTH bits: address of instr_o.
REQ-017 Port instr_ready_i, input, 1 bit: decode consumes the head entry.

Function
REQ-018 The block SHALL define credit as (queue occupancy + outstanding count), and imem_req_o SHALL equal pc_valid_i && !flush_i && state==RUN && credit<DEPTH, combinationally.
REQ-019 pc_ready_o SHALL equal imem_req_o && imem_gnt_i; on that cycle pc_i SHALL be pushed into a pending-PC FIFO and the outstanding count SHALL increment.
REQ-020 In RUN, on imem_rvalid_i, the block SHALL pop the pending PC and push {imem_rdata_i, pending PC} into the queue; the outstanding count SHALL decrement.
REQ-021 A response in cycle N SHALL make instr_valid_o high in cycle N+1 (FETCH_BYPASS_EN undefined).
REQ-022 instr_valid_o SHALL be high while the queue is non-empty; the head SHALL pop when instr_valid_o && instr_ready_i.
REQ-023 Simultaneous push and pop SHALL be legal at any occupancy, and credit gating SHALL guarantee the queue never overflows.
REQ-024 The FSM SHALL have states RUN and DRAIN, and flush_i SHALL clear the queue and the pending-PC FIFO on the next edge.
REQ-025 On flush, a drop counter SHALL load the outstanding count minus any response arriving in the same cycle; if that value is nonzero the FSM SHALL go to DRAIN, else it SHALL stay in RUN.
REQ-026 A response in the flush cycle SHALL be discarded.
REQ-027 In DRAIN, imem_req_o SHALL be 0, each imem_rvalid_i SHALL be discarded and SHALL decrement the drop counter, and the FSM SHALL return to RUN when the counter reaches 0.
REQ-028 flush_i asserted during DRAIN SHALL keep the current drop counter and clear the queue again.
REQ-029 imem_rvalid_i with no outstanding request SHALL be ignored.

Reset
REQ-030 rst low SHALL asynchronously force the following: state RUN, queue and pending FIFO empty, outstanding and drop counters 0, instr_valid_o 0, instr_o 0, instr_pc_o 0.
REQ-031 Reset mid-transaction SHALL abandon all in-flight requests without draining.

Configuration
REQ-032 With macro FETCH_BYPASS_EN defined, a RUN-state response arriving while the queue is empty and instr_ready_i is high SHALL drive instr_valid_o/instr_o/instr_pc_o in the same cycle and SHALL not be stored.
REQ-033 Without FETCH_BYPASS_EN, every response SHALL be stored first (REQ-021).

Structure
REQ-034 Package fetch_pkg SHALL hold WIDTH and DEPTH defaults, the RUN/DRAIN state enum, and the queue entry struct {instr, pc}.
REQ-035 One sub-module, sync_fifo, SHALL be parameterised by width and depth and instantiated twice: instruction queue and pending-PC FIFO.

Verification
REQ-036 Reset release, pc_i=0x0 valid, gnt=1, rvalid next cycle with 0x00500093 -> instr_valid_o=1, instr_o=0x00500093, instr_pc_o=0x0.
REQ-037 PCs 0x0/0x4/0x8/0xC granted, instr_ready_i=0 -> the 5th request (0x10) is held with imem_req_o=0 until one pop.
REQ-038 Two outstanding requests (0x8, 0xC), then flush_i -> two later rvalids dropped, DRAIN->RUN, and the next fetch of target 0x40 enters the queue alone.
REQ-039 flush_i coincident with rvalid, outstanding=1 -> nothing queued, FSM stays RUN.
REQ-040 rst pulled low with 2 queued and 1 outstanding -> all outputs 0 immediately, and the stale rvalid after release is ignored.
REQ-041 With FETCH_BYPASS_EN defined, empty queue, ready=1, rvalid 0x00000013 at 0x20 -> instr_valid_o the same cycle.
